// File: rtl/pseudo_ana_stk_n.sv
// Digital-to-pseudo-analog stick: per-axis frame-stepped centred positions.
// Define PSTK_ACCEL_EN to enable per-axis hold acceleration (step doubles).
module pseudo_ana_stk_n #(
  parameter int NAXES     = 2,
  parameter int W         = 8,
  parameter int STEP      = 15,
  parameter int RET_STEP  = 15,
  parameter int LIM       = 120,
  parameter int CENTER    = 127,
  parameter int TRIG_LINE = 0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [8:0]         PV,
  input  logic [NAXES-1:0]   POS,
  input  logic [NAXES-1:0]   NEG,
  input  logic               MODE,
  input  logic               CEN,
  output logic [NAXES*W-1:0] AOUT,
  output logic               UPD
);

  localparam int PW = W + 2;
  localparam logic [8:0] TRIG = 9'(TRIG_LINE);
  localparam logic signed [PW-1:0] LIM_S  = PW'(LIM);
  localparam logic signed [PW-1:0] RET_S  = PW'(RET_STEP);
  localparam logic signed [PW-1:0] STEP_S = PW'(STEP);
  localparam logic signed [PW-1:0] CEN_S  = PW'(CENTER);

  logic [8:0] ppv;
  logic       tick;
  logic       tick_q;

  // Edge on arrival at the trigger line, not on dwell
  assign tick = (PV == TRIG) && (ppv != PV);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ppv    <= TRIG;
      tick_q <= 1'b0;
      UPD    <= 1'b0;
    end else begin
      ppv    <= PV;
      tick_q <= tick;
      UPD    <= tick_q;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NAXES; i++) begin : g_axis
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] s;
      logic signed [PW-1:0] sum;
      logic signed [PW-1:0] nxt;
      logic                 up;
      logic                 dn;
      logic [W-1:0]         a_q;

      assign up = POS[i] & ~NEG[i];
      assign dn = NEG[i] & ~POS[i];

`ifdef PSTK_ACCEL_EN
      logic [1:0] h;
      logic [1:0] h_eff;
      logic       dir;

      // A reversal restarts acceleration from the base step
      assign h_eff = (dir == up) ? h : 2'd0;
      assign s     = STEP_S <<< h_eff;

      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          h   <= 2'd0;
          dir <= 1'b0;
        end else if (CEN) begin
          h <= 2'd0;
        end else if (tick) begin
          if (up | dn) begin
            h   <= (h_eff == 2'd3) ? 2'd3 : h_eff + 2'd1;
            dir <= up;
          end else begin
            h <= 2'd0;
          end
        end
      end
`else
      assign s = STEP_S;
`endif

      always_comb begin
        sum = p;
        nxt = p;
        unique case (1'b1)
          up:      sum = p + s;
          dn:      sum = p - s;
          default: sum = p;
        endcase
        if (up | dn) begin
          if (sum > LIM_S)
            nxt = LIM_S;
          else if (sum < -LIM_S)
            nxt = -LIM_S;
          else
            nxt = sum;
        end else if (MODE) begin
          nxt = p;
        end else if (p <= RET_S && p >= -RET_S) begin
          nxt = '0;
        end else if (p > 0) begin
          nxt = p - RET_S;
        end else begin
          nxt = p + RET_S;
        end
      end

      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          p   <= '0;
          a_q <= W'(CENTER);
        end else begin
          if (CEN)
            p <= '0;
          else if (tick)
            p <= nxt;
          a_q <= W'(p + CEN_S);
        end
      end

      assign AOUT[i*W +: W] = a_q;
    end
  endgenerate

endmodule
